// File: rtl/us_echo_rx_if.sv
// us_echo_rx_if: signal bundle between the ultrasonic echo receiver and its user.
//   start       : one-cycle pulse, transmit burst begins this cycle
//   rx_in       : asynchronous comparator output of the receive transducer
//   busy        : measurement in progress (blanking or listening)
//   valid       : one-cycle pulse, echo accepted and tof updated
//   timeout     : one-cycle pulse, listen window expired without acceptance
//   tof         : time of flight in clk cycles, held until the next valid
//   last_period : most recent carrier period measured while listening
// master drives start/rx_in; slave (the receiver) drives the results.
interface us_echo_rx_if;
  logic        start;
  logic        rx_in;
  logic        busy;
  logic        valid;
  logic        timeout;
  logic [23:0] tof;
  logic [15:0] last_period;

  modport master (output start, rx_in, input busy, valid, timeout, tof, last_period);
  modport slave  (input start, rx_in, output busy, valid, timeout, tof, last_period);
endinterface

// File: rtl/us_echo_rx.sv
// us_echo_rx: ultrasonic echo receiver. Synchronizes the comparator output,
// detects rising edges, and accepts an echo once MIN_CYCLES consecutive
// carrier periods fall inside [PERIOD_MIN, PERIOD_MAX]. Reports time of flight
// from start to the first edge of the accepted run.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : us_echo_rx_if.slave (start, rx_in in; busy, valid, timeout, tof,
//          last_period out)
// Build option: define US_RX_GLITCH_FILTER_EN to insert a registered 3-sample
// majority filter ahead of edge detection (rejects 1-cycle pulses, +2 cycles
// of latency).
module us_echo_rx #(
  parameter int PERIOD_MIN  = 640,
  parameter int PERIOD_MAX  = 712,
  parameter int MIN_CYCLES  = 8,
  parameter int BLANK_CYC   = 2700,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  us_echo_rx_if.slave bus
);
  localparam logic [15:0] P_MIN     = 16'(PERIOD_MIN);
  localparam logic [15:0] P_MAX     = 16'(PERIOD_MAX);
  localparam logic [7:0]  RUN_LAST  = 8'(MIN_CYCLES - 1);
  localparam logic [23:0] BLANK_END = 24'(BLANK_CYC - 1);
  localparam logic [23:0] TMO_END   = 24'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BLANK, LISTEN} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic        samp, rx_rise, in_band, accept;
  logic [23:0] elapsed_q, elapsed_d, cand_q, cand_d, tof_q, tof_d;
  logic [15:0] pcnt_q, pcnt_d, last_period_q, last_period_d;
  logic [7:0]  run_q, run_d;
  logic        seen_q, seen_d;
  logic        busy_q, busy_d, valid_q, valid_d, timeout_q, timeout_d;

`ifdef US_RX_GLITCH_FILTER_EN
  // Majority of the current and two previous synchronized samples.
  logic h1_q, h1_d, h2_q, h2_d, filt_q, filt_d;
  always_comb begin
    h1_d   = sync2_q;
    h2_d   = h1_q;
    filt_d = (sync2_q & h1_q) | (sync2_q & h2_q) | (h1_q & h2_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      h1_q   <= 1'b0;
      h2_q   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      h1_q   <= h1_d;
      h2_q   <= h2_d;
      filt_q <= filt_d;
    end
  end
  assign samp = filt_q;
`else
  assign samp = sync2_q;
`endif

  assign rx_rise = samp & ~prev_q;
  assign in_band = (pcnt_q >= P_MIN) && (pcnt_q <= P_MAX);

  always_comb begin
    sync1_d       = bus.rx_in;
    sync2_d       = sync1_q;
    prev_d        = samp;
    state_d       = state_q;
    elapsed_d     = elapsed_q;
    cand_d        = cand_q;
    run_d         = run_q;
    seen_d        = seen_q;
    tof_d         = tof_q;
    last_period_d = last_period_q;
    valid_d       = 1'b0;
    timeout_d     = 1'b0;
    accept        = 1'b0;
    pcnt_d        = (pcnt_q == 16'hFFFF) ? pcnt_q : pcnt_q + 16'd1;

    if (state_q != IDLE && elapsed_q != 24'hFFFFFF)
      elapsed_d = elapsed_q + 24'd1;

    case (state_q)
      BLANK: if (elapsed_q == BLANK_END) state_d = LISTEN;
      LISTEN: begin
        if (rx_rise) begin
          pcnt_d = 16'd1;
          if (!seen_q) begin
            // First edge only anchors the candidate; no period yet.
            seen_d = 1'b1;
            cand_d = elapsed_q;
            run_d  = 8'd0;
          end else begin
            last_period_d = pcnt_q;
            if (in_band) begin
              run_d  = run_q + 8'd1;
              accept = (run_q == RUN_LAST);
            end else begin
              run_d  = 8'd0;
              cand_d = elapsed_q;
            end
          end
        end
        // Acceptance takes priority over an expiring window on the same cycle.
        if (accept) begin
          valid_d = 1'b1;
          tof_d   = cand_q;
          state_d = IDLE;
        end else if (elapsed_q == TMO_END) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: ;
    endcase

    // A new start always wins the state, but any pulse for the old
    // measurement computed above still goes out.
    if (bus.start) begin
      state_d   = BLANK;
      elapsed_d = 24'd0;
      cand_d    = 24'd0;
      run_d     = 8'd0;
      pcnt_d    = 16'd0;
      seen_d    = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      prev_q        <= 1'b0;
      elapsed_q     <= 24'd0;
      cand_q        <= 24'd0;
      tof_q         <= 24'd0;
      pcnt_q        <= 16'd0;
      last_period_q <= 16'd0;
      run_q         <= 8'd0;
      seen_q        <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      elapsed_q     <= elapsed_d;
      cand_q        <= cand_d;
      tof_q         <= tof_d;
      pcnt_q        <= pcnt_d;
      last_period_q <= last_period_d;
      run_q         <= run_d;
      seen_q        <= seen_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.valid       = valid_q;
  assign bus.timeout     = timeout_q;
  assign bus.tof         = tof_q;
  assign bus.last_period = last_period_q;
endmodule

// File: tb/tb_us_echo_rx.sv
// tb_us_echo_rx: randomized and directed bench for us_echo_rx. A list-based
// model turns the pin pulse schedule into recognized edge times and derives
// the expected outputs for every cycle after a start.
module tb_us_echo_rx;
  localparam int P_MIN   = 640;
  localparam int P_MAX   = 712;
  localparam int MIN_CYC = 8;
  localparam int BLANK   = 2700;
  localparam int TMO     = 15500;
`ifdef US_RX_GLITCH_FILTER_EN
  localparam int LAT   = 4;
  localparam int NRAND = 1;
`else
  localparam int LAT   = 2;
  localparam int NRAND = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  us_echo_rx_if bus();

  us_echo_rx #(
    .PERIOD_MIN(P_MIN), .PERIOD_MAX(P_MAX), .MIN_CYCLES(MIN_CYC),
    .BLANK_CYC(BLANK), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {int s; int len;} pulse_t;
  pulse_t pulses[$];
  int     glitches[$];
  int     cyc;
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     chk_on = 1'b0;

  // Model of the current measurement: kind 0 idle, 1 accept, 2 timeout.
  int m_kind, m_ev, new_tof, old_tof, old_lp;
  int upd_t[$], upd_v[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic void build_model();
    int e[$];
    int seen, run, cand, last;
    seen = 0; run = 0; cand = 0; last = 0;
    upd_t.delete(); upd_v.delete();
    m_kind = 2; m_ev = TMO;
    foreach (pulses[i]) e.push_back(pulses[i].s + LAT);
    e.sort();
    foreach (e[i]) begin
      int per;
      if (e[i] < BLANK || e[i] > TMO - 1) continue;
      if (seen == 0) begin
        seen = 1; cand = e[i]; run = 0;
      end else begin
        per = e[i] - last;
        if (per > 65535) per = 65535;
        upd_t.push_back(e[i] + 1);
        upd_v.push_back(per);
        if (per >= P_MIN && per <= P_MAX) begin
          run++;
          if (run == MIN_CYC) begin
            m_kind = 1; m_ev = e[i] + 1; new_tof = cand;
            break;
          end
        end else begin
          run = 0; cand = e[i];
        end
      end
      last = e[i];
    end
  endfunction

  function automatic logic [31:0] e_busy(int c);
    return 32'(m_kind != 0 && c < m_ev);
  endfunction
  function automatic logic [31:0] e_valid(int c);
    return 32'(m_kind == 1 && c == m_ev);
  endfunction
  function automatic logic [31:0] e_tmo(int c);
    return 32'(m_kind == 2 && c == m_ev);
  endfunction
  function automatic logic [31:0] e_tof(int c);
    return (m_kind == 1 && c >= m_ev) ? 32'(new_tof) : 32'(old_tof);
  endfunction
  function automatic logic [31:0] e_lp(int c);
    int v;
    v = old_lp;
    foreach (upd_t[i]) if (upd_t[i] <= c) v = upd_v[i];
    return 32'(v);
  endfunction

  function automatic logic pin(int c);
    logic v;
    v = 1'b0;
    foreach (pulses[i]) if (c >= pulses[i].s && c < pulses[i].s + pulses[i].len) v = 1'b1;
    foreach (glitches[i]) if (glitches[i] == c) v = ~v;
    return v;
  endfunction

  // Single compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy",        32'(bus.busy),        e_busy(cyc));
      chk("valid",       32'(bus.valid),       e_valid(cyc));
      chk("timeout",     32'(bus.timeout),     e_tmo(cyc));
      chk("tof",         32'(bus.tof),         e_tof(cyc));
      chk("last_period", 32'(bus.last_period), e_lp(cyc));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    bus.rx_in = pin(cyc);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic add_pulse(input int s, input int len);
    pulse_t p;
    p.s = s; p.len = len;
    pulses.push_back(p);
  endtask

  task automatic add_burst(input int first, input int n, input int per);
    for (int k = 0; k < n; k++) add_pulse(first + k * per, per / 2);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    old_tof = int'(e_tof(cyc + 1));
    old_lp  = int'(e_lp(cyc + 1));
    cyc = 0;
    build_model();
    bus.rx_in = pin(0);
  endtask

  task automatic rst_mid();
    rst = 1'b1;
    tick();
    m_kind = 0; m_ev = -1; old_tof = 0; old_lp = 0;
    upd_t.delete(); upd_v.delete();
    pulses.delete(); glitches.delete();
    bus.rx_in = 1'b0;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_tof",  32'(bus.tof), 32'd0);
    chk("rst_mid_lp",   32'(bus.last_period), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int s, per, last_rise, r;
    bus.start = 1'b0; bus.rx_in = 1'b0;
    cyc = 0; m_kind = 0; m_ev = -1; new_tof = 0; old_tof = 0; old_lp = 0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    chk("rst_busy",    32'(bus.busy), 32'd0);
    chk("rst_valid",   32'(bus.valid), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    chk("rst_tof",     32'(bus.tof), 32'd0);
    chk("rst_lp",      32'(bus.last_period), 32'd0);
    tick(); rst = 1'b0; tick(); tick();

    // 12 periods of 676 from 10000.
    pulses.delete(); add_burst(10000, 13, 676);
    do_start();
    chk("t1_model_ev",  32'(m_ev), 32'(10000 + LAT + 5408 + 1));
    chk("t1_model_tof", 32'(new_tof), 32'(10000 + LAT));
    run_to(m_ev);
    chk("t1_valid", 32'(bus.valid), 32'd1);
    chk("t1_tof",   32'(bus.tof), 32'(10000 + LAT));
    chk("t1_lp",    32'(bus.last_period), 32'd676);
    run_to(m_ev + 3);

    // Out-of-band 800 carrier: window expires, tof holds.
    pulses.delete(); add_burst(10000, 7, 800);
    do_start();
    chk("t2_model_kind", 32'(m_kind), 32'd2);
    run_to(TMO);
    chk("t2_timeout", 32'(bus.timeout), 32'd1);
    chk("t2_busy",    32'(bus.busy), 32'd0);
    chk("t2_tof",     32'(bus.tof), 32'(10000 + LAT));
    chk("t2_lp",      32'(bus.last_period), 32'd800);
    run_to(TMO + 3);

    // Pulses inside blanking are ignored.
    pulses.delete();
    add_pulse(1000, 4); add_pulse(1010, 4); add_pulse(1020, 4);
    add_burst(5000, 13, 676);
    do_start();
    run_to(m_ev);
    chk("t3_tof", 32'(bus.tof), 32'(5000 + LAT));
    chk("t3_lp",  32'(bus.last_period), 32'd676);
    run_to(m_ev + 3);

    // Short period restarts the run; candidate moves to its closing edge.
    pulses.delete();
    for (int k = 0; k <= 5; k++)  add_pulse(2800 + 676 * k, 338);
    for (int k = 0; k <= 10; k++) add_pulse(2800 + 3780 + 676 * k, 338);
    do_start();
    chk("t4_model_tof", 32'(new_tof), 32'(2800 + 3780 + LAT));
    run_to(m_ev);
    chk("t4_tof", 32'(bus.tof), 32'(6580 + LAT));
    run_to(m_ev + 3);

    // Restart mid-LISTEN.
    pulses.delete();
    do_start();
    run_to(2800);
    add_burst(8000, 13, 676);
    do_start();
    run_to(m_ev);
    chk("t5_valid", 32'(bus.valid), 32'd1);
    chk("t5_tof",   32'(bus.tof), 32'(8000 + LAT));
    run_to(m_ev + 3);

    // Reset mid-LISTEN.
    pulses.delete(); add_burst(3000, 13, 676);
    do_start();
    run_to(4000);
    rst_mid();

`ifdef US_RX_GLITCH_FILTER_EN
    // One-cycle inversions every 100 cycles during a good burst.
    pulses.delete(); glitches.delete(); add_burst(6000, 13, 676);
    for (int g = 6050; g < 6000 + 12 * 676; g += 100) begin
      int pos;
      pos = (g - 6000) % 676;
      if (pos > 3 && pos < 673 && (pos < 335 || pos > 341)) glitches.push_back(g);
    end
    do_start();
    run_to(m_ev);
    chk("flt_valid", 32'(bus.valid), 32'd1);
    chk("flt_tof",   32'(bus.tof), 32'd6004);
    run_to(m_ev + 3);
    glitches.delete();
`endif

    // Randomized carriers, boundary periods weighted in.
    for (int t = 0; t < NRAND; t++) begin
      pulses.delete();
      s = int'($urandom_range(2800, 2650));
      add_pulse(s, 300);
      for (int k = 0; k < 10; k++) begin
        r = int'($urandom % 10);
        case (r)
          0: per = 639;
          1: per = 713;
          2: per = int'($urandom_range(800, 713));
          3: per = 640;
          4: per = 712;
          default: per = int'($urandom_range(712, 640));
        endcase
        s += per;
        add_pulse(s, 300);
      end
      last_rise = s;
      do_start();
      if (m_kind == 1) run_to(m_ev + 3);
      else begin
        run_to(last_rise + LAT + 5);
        rst_mid();
      end
    end

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/us_echo_rx.md
# us_echo_rx

Receive-side companion to the ultrasonic burst transmitter on the Pmod US board. It takes the digitized (comparator) output of the ultrasonic receiver transducer and checks that the incoming carrier stays in band for a minimum number of periods. On acceptance it reports time-of-flight in `clk` cycles, measured from the transmitter's `start` pulse to the first edge of the accepted run. It also reports the last measured carrier period, and sits beside the transmitter timers for rangefinding and link tests.

## Interface
- `PERIOD_MIN`, 640: shortest accepted carrier period, clk cycles (nominal 676 = 2×338 at 27 MHz).
- `PERIOD_MAX`, 712: longest accepted carrier period, clk cycles.
- `MIN_CYCLES`, 8: consecutive in-band periods required to accept an echo (1..255).
- `BLANK_CYC`, 2700: cycles after `start` during which edges are ignored (direct-coupling blanking).
- `TIMEOUT_CYC`, 1000000: cycles after `start` with no acceptance before `timeout` fires; must exceed `BLANK_CYC`.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; transmit burst begins this cycle.
- `rx_in`  in  1  asynchronous comparator output from the receiver transducer.
- `busy`  out  1  high in BLANK or LISTEN.
- `valid`  out  1  one-cycle pulse; echo accepted, `tof` updated.
- `timeout`  out  1  one-cycle pulse; window expired without acceptance.
- `tof`  out  24  time of flight, clk cycles; holds until the next `valid`.
- `last_period`  out  16  most recent measured period in LISTEN, saturating at 16'hFFFF.

## Operation
- Input path: 2-flop synchronizer, then a previous-sample register. A rising edge is recognized when the synchronized sample is 1 and the previous sample is 0.
- `elapsed` (24 b): cleared to 0 in the cycle `start` is sampled. It increments every cycle after that while busy and saturates at 2^24−1.
- `pcnt` (16 b): period counter. Reset to 1 on each recognized edge in LISTEN, otherwise increments and saturates at 16'hFFFF.
- FSM states: IDLE, BLANK, LISTEN.
  - IDLE → BLANK on `start`.
  - BLANK → LISTEN when `elapsed` == `BLANK_CYC`−1.
  - LISTEN → IDLE on acceptance or on `elapsed` == `TIMEOUT_CYC`−1.
- In LISTEN, the first recognized edge sets `cand` = `elapsed` and `run` = 0.
- On each later edge, `last_period` <= `pcnt`.
  - If PERIOD_MIN ≤ `pcnt` ≤ PERIOD_MAX: `run`++.
  - Otherwise: `run` = 0 and `cand` = `elapsed` of this edge.
- Acceptance: when `run` reaches `MIN_CYCLES`, in the next cycle `tof` <= `cand`, `valid`=1, and the FSM returns to IDLE.
- Timeout: `timeout`=1 for one cycle. `tof` and `last_period` are unchanged.
- `start` while busy restarts the measurement: `elapsed`, `run`, `cand` and `pcnt` are cleared and the FSM enters BLANK. No `valid` or `timeout` is emitted for the aborted measurement.
- Acceptance and timeout on the same edge cycle: acceptance wins and `timeout` stays 0.
- `start` coincident with an acceptance or timeout cycle: the pulse for the old measurement is still emitted, and the new measurement begins.
- Edges in IDLE or BLANK: ignored; `last_period` is not updated.

## Timing
- Reset: FSM=IDLE; `busy`, `valid`, `timeout`=0; `tof`, `last_period`=0; synchronizer flops=0.
- `busy` rises the cycle after `start` is sampled.
- Pin-to-recognition latency: 2 cycles without the filter, 4 with it. `tof` is not compensated for this latency.
- `valid` asserts exactly 1 cycle after the edge that completes the `MIN_CYCLES`-th in-band period.
- `busy` falls in the same cycle `valid` or `timeout` is high.
- `rst` mid-measurement: next cycle in reset state, with no pulse emitted.

## Configuration
- `US_RX_GLITCH_FILTER_EN` defined: a registered 3-sample majority filter sits between the synchronizer and edge detect. Pulses of 1 cycle are rejected, and latency grows by 2 cycles.
- Undefined: no filter; a single-cycle high pulse produces an edge.

## Test plan
- Burst of 12 periods of 676, first pin edge at cycle 10000 after `start` -> `valid` at 10000+2+5408+1, `tof`=10002, `last_period`=676.
- Burst of period 800 at 10000 -> no `valid`; `timeout` pulse at `elapsed`=999999; `tof` unchanged.
- Edge pulses at cycle 1000 (in blank) plus burst at 5000 -> `tof`=5002, `last_period`=676.
- 5 good periods, one 400-cycle period, then 10 good periods -> `tof` = elapsed of the edge ending the short period.
- Second `start` mid-LISTEN, then burst at 8000 after it -> single `valid`, `tof`=8002; `rst` mid-LISTEN -> no pulses, outputs 0.
- Filter enabled: 1-cycle glitches every 100 cycles during a good burst at 6000 -> `tof`=6004, and acceptance is undisturbed.
